// File: rtl/fp_root_pkg.sv
// Shared definitions for the Nth-root datapath: fixed-point constants,
// fp32 field positions, front-end FSM states and the classification flags.
package fp_root_pkg;

   // Q8.27 representation of 1.0
   localparam logic [35:0] Q_ONE     = 36'h008000000;
   localparam int          FP_BIAS   = 127;
   localparam logic [7:0]  EXP_MAX   = 8'hFF;

   // fp32 field slices {sign, exp[7:0], frac[22:0]}
   localparam int SIGN_BIT  = 31;
   localparam int EXP_MSB   = 30;
   localparam int EXP_LSB   = 23;
   localparam int FRAC_MSB  = 22;
   localparam int FRAC_LSB  = 0;

   // Position of the integer (hidden) bit inside the Q8.27 significand
   localparam int Q_INT_BIT = 27;

   typedef enum logic {
      IDLE = 1'b0,
      NORM = 1'b1
   } state_t;

   typedef struct packed {
      logic zero;
      logic inf;
      logic nan;
      logic sub;
   } flags_t;

endpackage

// File: rtl/fp32_unpack.sv
// fp32_unpack: front end of the Nth-root datapath. Splits an IEEE-754
// single into a biased exponent and a Q8.27 significand for the CORDIC,
// classifies special values, and (with FP32_UNPACK_SUBNORM_EN defined)
// normalises subnormals one bit per cycle. Without the macro, subnormals
// flush to zero with single-cycle latency and in_ready is always high.
// The output is a one-cycle valid pulse; the consumer cannot stall.
module fp32_unpack
   import fp_root_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_data,
   output logic               out_valid,
   output logic signed [35:0] x_out,
   output logic [7:0]         e_out,
   output logic [4:0]         norm_shift,
   output logic               sign_out,
   output logic               flag_zero,
   output logic               flag_inf,
   output logic               flag_nan,
   output logic               flag_sub
);

   // Place a 23-bit fraction under a given hidden bit in Q8.27
   function automatic logic signed [35:0] frac_to_q(input logic hidden,
                                                    input logic [22:0] frac);
      return signed'({8'b0, hidden, frac, 4'b0});
   endfunction

   logic [7:0]         exp_p0;
   logic [22:0]        frac_p0;
   logic signed [35:0] x_p0;
   logic [7:0]         e_p0;
   flags_t             flags_p0;
   flags_t             flags_q;

   assign exp_p0  = in_data[EXP_MSB:EXP_LSB];
   assign frac_p0 = in_data[FRAC_MSB:FRAC_LSB];

   assign flag_zero = flags_q.zero;
   assign flag_inf  = flags_q.inf;
   assign flag_nan  = flags_q.nan;
   assign flag_sub  = flags_q.sub;

`ifdef FP32_UNPACK_SUBNORM_EN
   logic sub_p0;
`endif

   // Classify the incoming operand and form its single-cycle result
   always_comb begin
      flags_p0 = '0;
      x_p0     = '0;
      e_p0     = '0;
`ifdef FP32_UNPACK_SUBNORM_EN
      sub_p0   = 1'b0;
`endif
      if (exp_p0 == 8'd0) begin
         if (frac_p0 == '0) begin
            flags_p0.zero = 1'b1;
         end else begin
`ifdef FP32_UNPACK_SUBNORM_EN
            sub_p0 = 1'b1;
`else
            // flush-to-zero: reported as an ordinary zero
            flags_p0.zero = 1'b1;
`endif
         end
      end else if (exp_p0 == EXP_MAX) begin
         e_p0 = EXP_MAX;
         if (frac_p0 == '0) begin
            flags_p0.inf = 1'b1;
            x_p0         = signed'(Q_ONE);
         end else begin
            flags_p0.nan = 1'b1;
            x_p0         = frac_to_q(1'b1, frac_p0);
         end
      end else begin
         e_p0 = exp_p0;
         x_p0 = frac_to_q(1'b1, frac_p0);
      end
   end

`ifdef FP32_UNPACK_SUBNORM_EN
   state_t             state;
   logic signed [35:0] sh_p1;
   logic [4:0]         cnt_p1;
   logic               sign_p1;
   logic signed [35:0] sh_nxt;
   logic [4:0]         cnt_nxt;

   assign in_ready = (state == IDLE);
   assign sh_nxt   = sh_p1 <<< 1;
   assign cnt_nxt  = cnt_p1 + 5'd1;

   // Normalisation datapath: preload while idle, shift once per NORM cycle
   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         sh_p1   <= frac_to_q(1'b0, frac_p0);
         cnt_p1  <= 5'd0;
         sign_p1 <= in_data[SIGN_BIT];
      end else begin
         sh_p1   <= sh_nxt;
         cnt_p1  <= cnt_nxt;
      end
   end

   // Control FSM and registered outputs; a subnormal detours through NORM
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         out_valid  <= 1'b0;
         x_out      <= '0;
         e_out      <= '0;
         norm_shift <= '0;
         sign_out   <= 1'b0;
         flags_q    <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (sub_p0) begin
                     state <= NORM;
                  end else begin
                     out_valid  <= 1'b1;
                     x_out      <= x_p0;
                     e_out      <= e_p0;
                     norm_shift <= 5'd0;
                     sign_out   <= in_data[SIGN_BIT];
                     flags_q    <= flags_p0;
                  end
               end
            end
            NORM: begin
               // leave as soon as the hidden bit reaches the integer position
               if (sh_nxt[Q_INT_BIT]) begin
                  state      <= IDLE;
                  out_valid  <= 1'b1;
                  x_out      <= sh_nxt;
                  e_out      <= 8'd1;
                  norm_shift <= cnt_nxt;
                  sign_out   <= sign_p1;
                  flags_q    <= '{zero: 1'b0, inf: 1'b0, nan: 1'b0, sub: 1'b1};
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   assign in_ready = 1'b1;

   // Every operand completes in one cycle; subnormals arrive as zeros
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         x_out      <= '0;
         e_out      <= '0;
         norm_shift <= '0;
         sign_out   <= 1'b0;
         flags_q    <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            x_out      <= x_p0;
            e_out      <= e_p0;
            norm_shift <= 5'd0;
            sign_out   <= in_data[SIGN_BIT];
            flags_q    <= flags_p0;
         end
      end
   end
`endif

endmodule
